// File: rtl/buzz_arbiter.sv
// Quiz buzzer front end: synchronises contestant buttons, tracks false starts
// and latches the first eligible buzz-in after the controller arms the round.
module buzz_arbiter #(
  parameter int N_PLAYERS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_PLAYERS-1:0] key,
  input  logic                 clear,
  input  logic                 arm,
  input  logic                 endtime,
  output logic                 stoptime,
  output logic                 winner_valid,
  output logic [ID_W-1:0]      winner_id,
  output logic [N_PLAYERS-1:0] foul_mask,
  output logic                 timeout,
  output logic                 armed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t                                 state_r;
  logic [SYNC_STAGES-1:0][N_PLAYERS-1:0]  sync_r;
  logic [SYNC_STAGES-1:0]                 fill_r;
  logic [N_PLAYERS-1:0]                   prev_r;
  logic [N_PLAYERS-1:0]                   low_seen_r;
  logic [N_PLAYERS-1:0]                   synced_s;
  logic [N_PLAYERS-1:0]                   rise_s;
  logic [N_PLAYERS-1:0]                   elig_s;

  // Lowest set index of a request vector; lowest index has priority.
  function automatic logic [ID_W-1:0] lowest_index(input logic [N_PLAYERS-1:0] req);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Button synchronisers and edge-history registers; they run in every state.
  // fill_r marks when the chain holds real samples, and low_seen_r stops a key
  // that was already held at reset release from registering as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r     <= {(SYNC_STAGES*N_PLAYERS){1'b0}};
      fill_r     <= {SYNC_STAGES{1'b0}};
      prev_r     <= {N_PLAYERS{1'b0}};
      low_seen_r <= {N_PLAYERS{1'b0}};
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], key};
      fill_r     <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      prev_r     <= synced_s;
      low_seen_r <= low_seen_r | (fill_r[SYNC_STAGES-1] ? ~synced_s : {N_PLAYERS{1'b0}});
    end
  end

  // Rise detection and eligibility (fouled players never count).
  always_comb begin
    synced_s = sync_r[SYNC_STAGES-1];
    rise_s   = synced_s & ~prev_r & low_seen_r;
    elig_s   = rise_s & ~foul_mask;
  end

  // Round state machine with registered outputs; clear beats everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      stoptime     <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= {ID_W{1'b0}};
      foul_mask    <= {N_PLAYERS{1'b0}};
      timeout      <= 1'b0;
      armed        <= 1'b0;
    end else if (clear) begin
      state_r      <= IDLE;
      stoptime     <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= {ID_W{1'b0}};
      foul_mask    <= {N_PLAYERS{1'b0}};
      timeout      <= 1'b0;
      armed        <= 1'b0;
    end else begin
      stoptime <= 1'b0;
      case (state_r)
        IDLE: begin
          foul_mask <= foul_mask | rise_s;
          if (arm) begin
            state_r <= ARMED;
            armed   <= 1'b1;
          end else begin
            armed   <= 1'b0;
          end
        end
        ARMED: begin
          if (|elig_s) begin
            state_r      <= LOCKED;
            winner_id    <= lowest_index(elig_s);
            winner_valid <= 1'b1;
            stoptime     <= 1'b1;
            armed        <= 1'b0;
          end else if (endtime) begin
            state_r <= TIMEOUT;
            timeout <= 1'b1;
            armed   <= 1'b0;
          end else begin
            armed   <= 1'b1;
          end
        end
        LOCKED: begin
          state_r <= LOCKED;
        end
        TIMEOUT: begin
          state_r <= TIMEOUT;
        end
        default: begin
          state_r <= IDLE;
          armed   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzz_arbiter.sv
// Self-checking bench for buzz_arbiter: per-cycle vector table fed through a
// scoreboard queue, plus hand-written reset and held-key sequences.
module tb_buzz_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic       clear;
  logic       arm;
  logic       endtime;
  logic       stoptime;
  logic       winner_valid;
  logic [1:0] winner_id;
  logic [3:0] foul_mask;
  logic       timeout;
  logic       armed;

  int checks   = 0;
  int failures = 0;

  buzz_arbiter #(.N_PLAYERS(4), .SYNC_STAGES(2), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .clear(clear), .arm(arm),
    .endtime(endtime), .stoptime(stoptime), .winner_valid(winner_valid),
    .winner_id(winner_id), .foul_mask(foul_mask), .timeout(timeout),
    .armed(armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] k;
    logic       a;
    logic       e;
    logic       c;
    logic [9:0] exp;  // {stoptime, winner_valid, winner_id, foul_mask, timeout, armed}
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t v(string nm, logic [3:0] k, logic a, logic e, logic c,
                             logic st, logic wv, logic [1:0] id, logic [3:0] fm,
                             logic to, logic ar);
    vec_t r;
    r.nm = nm; r.k = k; r.a = a; r.e = e; r.c = c;
    r.exp = {st, wv, id, fm, to, ar};
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle2();
    vecs.push_back(v("idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    vec_t cur;
    vec_t got;

    rst_n = 1'b0; key = 4'b0000; clear = 1'b0; arm = 1'b0; endtime = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {stoptime, winner_valid, winner_id, foul_mask, timeout, armed}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single winner, two-edge synchroniser latency, held outputs
    vecs.push_back(v("s1_arm",    4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s1_k2a",    4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s1_k2b",    4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s1_win",    4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s1_hold",   4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s1_endign", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s1_armign", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s1_clear",  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    idle2();
    // simultaneous rises: lowest index wins, later press ignored
    vecs.push_back(v("s2_arm",    4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s2_pa",     4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s2_pb",     4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s2_win",    4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s2_hold",   4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s2_k0a",    4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s2_k0b",    4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s2_k0c",    4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s2_clear",  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    idle2();
    // false start in IDLE, fouled key ignored, key3 wins
    vecs.push_back(v("s3_fa",     4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s3_fb",     4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s3_foul",   4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0));
    vecs.push_back(v("s3_keep",   4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0));
    vecs.push_back(v("s3_arm",    4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
    vecs.push_back(v("s3_k0a",    4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
    vecs.push_back(v("s3_k0b",    4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
    vecs.push_back(v("s3_k0ign",  4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
    vecs.push_back(v("s3_k3a",    4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
    vecs.push_back(v("s3_k3b",    4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1));
    vecs.push_back(v("s3_win",    4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'b0001, 1'b0, 1'b0));
    vecs.push_back(v("s3_hold",   4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0001, 1'b0, 1'b0));
    vecs.push_back(v("s3_clear",  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    idle2();
    // timeout with no buzz, later inputs ignored
    vecs.push_back(v("s4_arm",    4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s4_end",    4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(v("s4_k1a",    4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(v("s4_k1b",    4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(v("s4_k1ign",  4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(v("s4_ign",    4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0));
    vecs.push_back(v("s4_clear",  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    idle2();
    // rise and endtime together: rise wins
    vecs.push_back(v("s5_arm",    4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s5_k2a",    4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s5_k2b",    4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s5_winend", 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s5_hold",   4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s5_clear",  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    idle2();
    // rise coincident with clear: no stoptime, no foul afterwards
    vecs.push_back(v("s6_arm",    4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s6_k0a",    4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s6_k0b",    4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1));
    vecs.push_back(v("s6_clrrise",4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s6_held",   4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    idle2();
    // foul recorded in the same cycle as arm; held fouled key never wins
    vecs.push_back(v("s7_k2a",    4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s7_k2b",    4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    vecs.push_back(v("s7_armfoul",4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b1));
    vecs.push_back(v("s7_k0a",    4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b1));
    vecs.push_back(v("s7_k0b",    4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b1));
    vecs.push_back(v("s7_win",    4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0100, 1'b0, 1'b0));
    vecs.push_back(v("s7_clear",  4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0));
    idle2();

    for (int i = 0; i < vecs.size(); i++) begin
      cur = vecs[i];
      @(negedge clk);
      key = cur.k; arm = cur.a; endtime = cur.e; clear = cur.c;
      sb.push_back(cur);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk(got.nm, {22'd0, stoptime, winner_valid, winner_id, foul_mask, timeout, armed},
          {22'd0, got.exp});
    end
    @(negedge clk);
    key = 4'b0000; arm = 1'b0; endtime = 1'b0; clear = 1'b0;

    // key held through reset release and arm: no rise until released and re-pressed
    @(negedge clk);
    key = 4'b0010;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("held_no_foul", {28'd0, foul_mask}, 32'd0);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("held_armed", {31'd0, armed}, 32'd1);
    repeat (4) @(negedge clk);
    chk("held_no_win", {31'd0, winner_valid}, 32'd0);
    key = 4'b0000;
    repeat (3) @(negedge clk);
    key = 4'b0010;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk);
      #1;
      if (stoptime) found = 1'b1;
    end
    chk("repress_stoptime", {31'd0, found}, 32'd1);
    chk("repress_id", {30'd0, winner_id}, 32'd1);
    @(negedge clk);
    chk("locked_valid", {31'd0, winner_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_locked", {22'd0, stoptime, winner_valid, winner_id, foul_mask, timeout, armed}, 32'd0);
    key = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buzz_arbiter.md
Name: buzz_arbiter

Overview:
- Upstream front end of the quiz-responder controller.
- Synchronises the raw contestant buttons, arms on the controller's start-timer pulse, and picks the first valid buzz-in.
- Emits the stoptime pulse plus winner identity that the controller consumes. Also reports a timeout when endtime arrives with no buzz.
- Detects false starts (presses before arming) and locks those contestants out for the rest of the round.

Parameters:
- N_PLAYERS, 4, number of contestant buttons (2..8).
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser (>=2).
- ID_W, 2, width of winner_id; must equal ceil(log2(N_PLAYERS)).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key  in  N_PLAYERS  raw contestant buttons, active-high, asynchronous to clk.
- clear  in  1  new-round request, level sampled each cycle.
- arm  in  1  start-timer pulse from controller (starttimer).
- endtime  in  1  answer window expired.
- stoptime  out  1  one-cycle pulse when a winner is latched.
- winner_valid  out  1  high while a winner is held.
- winner_id  out  ID_W  index of winning contestant.
- foul_mask  out  N_PLAYERS  bit i set = contestant i false-started this round.
- timeout  out  1  high while the round ended with no buzz.
- armed  out  1  high in ARMED state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - All synchroniser and edge registers cleared.
  - stoptime=0, winner_valid=0, winner_id=0, foul_mask=0, timeout=0, armed=0.
- Synchroniser: each key bit passes through SYNC_STAGES flops. A rise is defined as synced=1 with previous synced=0.
  - A key first sampled high at edge t produces its rise in the cycle after edge t+SYNC_STAGES-1.
  - Registered outputs update at edge t+SYNC_STAGES.
- Eligible rise: rise on bit i with foul_mask[i]=0.
- Priority when several eligible rises fall in the same cycle: lowest index wins.
- States:
  - IDLE: armed=0.
    - Any rise on bit i sets foul_mask[i]; multiple bits may set in one cycle.
    - arm=1 -> ARMED, even if a rise occurs in the same cycle (the foul is still recorded).
    - endtime is ignored.
  - ARMED: armed=1.
    - Eligible rise -> LOCKED: winner_id=index, winner_valid=1, stoptime=1 for exactly one cycle.
    - Otherwise endtime=1 -> TIMEOUT with timeout=1.
    - If an eligible rise and endtime occur in the same cycle, the rise wins.
    - Rises from fouled players are ignored; they neither win nor change foul_mask.
    - arm is ignored.
  - LOCKED: outputs held. Further presses, arm and endtime are ignored; no additional stoptime pulses.
  - TIMEOUT: outputs held; all inputs except clear are ignored.
- clear=1, any state: next edge goes to IDLE and zeroes winner_valid, winner_id, foul_mask, timeout, armed and stoptime.
  - clear overrides every other input in the same cycle, including a simultaneous eligible rise (no stoptime is issued).
- A key held high across arm has no new rise, so it cannot win. It must be released and pressed again.
  - If its original rise was in IDLE, it is already fouled.
- Synchroniser/edge registers keep running in all states, so a release followed by a press is tracked continuously.
- Reset asserted mid-round (any state) returns to the reset values immediately. A key high at reset release does not generate a rise until it goes low and high again.

Test Plan:
- Reset then arm; key=4'b0100 held from edge 10 -> stoptime=1 for exactly one cycle starting edge 12; winner_id=2, winner_valid=1; foul_mask=0.
- Armed; key=4'b1010 rising in the same sample cycle -> winner_id=1, exactly one stoptime pulse; a later key[0] press causes no change.
- In IDLE press key[0] then release; arm; press key[0] again, then key[3] -> foul_mask=4'b0001, key[0] ignored, winner_id=3.
- Armed with no key; endtime=1 -> timeout=1, winner_valid=0, stoptime never asserted; a later key[1] press causes no change; clear -> all outputs 0, state IDLE.
- Armed; key[2] rise and endtime in the same cycle -> winner_id=2, timeout=0. Separately, rise coincident with clear -> no stoptime, all outputs 0.
- key[1] held high from before arm through the ARMED state -> no winner; release then re-press -> winner_id=1. Reset asserted in LOCKED -> outputs 0 asynchronously.
